// File: rtl/serial_deser.sv
// serial_deser: collects an LSB-first bit-serial two's-complement word
// into a WIDTH-bit parallel register with a one-deep valid/ready output
// stage, a sticky overrun flag and a one-cycle frame-abort pulse.
module serial_deser #(
    parameter int WIDTH = 8
) (
    input  logic             t_clk,
    input  logic             r,
    input  logic             y_in,
    input  logic             bit_en,
    input  logic             sof,
    input  logic             word_ready,
    input  logic             clr_ovr,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    output logic             sign,
    output logic             overrun,
    output logic             frame_err
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             sign_q, sign_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             ferr_q, ferr_d;

    logic [WIDTH-1:0] first_bit;   // fresh frame: current bit at position 0
    logic [WIDTH-1:0] shreg_ins;   // partial word with current bit inserted
    logic             complete;

    assign word_out   = word_q;
    assign sign       = sign_q;
    assign word_valid = valid_q;
    assign overrun    = ovr_q;
    assign frame_err  = ferr_q;

    // Next-state logic for the frame FSM, shift register and output stage
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        word_d    = word_q;
        sign_d    = sign_q;
        valid_d   = valid_q;
        ovr_d     = ovr_q;
        ferr_d    = 1'b0;
        complete  = 1'b0;

        first_bit = '0;
        first_bit[0] = y_in;
        shreg_ins = shreg_q;
        shreg_ins[cnt_q] = y_in;

        case (state_q)
            IDLE: begin
                // Bits arriving without a start-of-frame marker are ignored.
                if (bit_en && sof) begin
                    shreg_d = first_bit;
                    cnt_d   = CNT_ONE;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_en) begin
                    if (sof) begin
                        // Abort the partial frame and restart on this bit.
                        shreg_d = first_bit;
                        cnt_d   = CNT_ONE;
                        ferr_d  = 1'b1;
                    end else if (cnt_q == CNT_LAST) begin
                        complete = 1'b1;
                        shreg_d  = shreg_ins;
                        cnt_d    = '0;
                        state_d  = IDLE;
                    end else begin
                        shreg_d = shreg_ins;
                        cnt_d   = cnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Clear first so a simultaneous new drop still leaves overrun set.
        if (clr_ovr) begin
            ovr_d = 1'b0;
        end

        if (complete) begin
            if (!valid_q || word_ready) begin
                word_d  = shreg_ins;
                sign_d  = shreg_ins[WIDTH-1];
                valid_d = 1'b1;
            end else begin
                // Output still occupied: drop the new word, keep the old one.
                ovr_d = 1'b1;
            end
        end else if (valid_q && word_ready) begin
            valid_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge t_clk or negedge r) begin
        if (!r) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            word_q  <= '0;
            sign_q  <= 1'b0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            word_q  <= word_d;
            sign_q  <= sign_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
        end
    end

endmodule

// File: tb/tb_serial_deser.sv
// Directed bench for serial_deser at WIDTH=8.
module tb_serial_deser;

    localparam int WIDTH = 8;

    logic             t_clk;
    logic             r;
    logic             y_in;
    logic             bit_en;
    logic             sof;
    logic             word_ready;
    logic             clr_ovr;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             sign;
    logic             overrun;
    logic             frame_err;

    int checks   = 0;
    int failures = 0;

    // Words presented by the DUT while the monitor is enabled
    logic             mon_en = 1'b0;
    logic [WIDTH-1:0] cap_w[$];
    logic             cap_s[$];

    serial_deser #(.WIDTH(WIDTH)) dut (
        .t_clk      (t_clk),
        .r          (r),
        .y_in       (y_in),
        .bit_en     (bit_en),
        .sof        (sof),
        .word_ready (word_ready),
        .clr_ovr    (clr_ovr),
        .word_out   (word_out),
        .word_valid (word_valid),
        .sign       (sign),
        .overrun    (overrun),
        .frame_err  (frame_err)
    );

    initial t_clk = 1'b0;
    always #5 t_clk = ~t_clk;

    always @(negedge t_clk) begin
        if (mon_en && word_valid) begin
            cap_w.push_back(word_out);
            cap_s.push_back(sign);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one bit for one clock; returns 1 time unit after the edge.
    task automatic send_bit(input logic b, input logic s);
        @(negedge t_clk);
        y_in   = b;
        bit_en = 1'b1;
        sof    = s;
        @(posedge t_clk);
        #1;
    endtask

    // n idle clocks with bit_en low
    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge t_clk);
            bit_en = 1'b0;
            sof    = 1'b0;
            @(posedge t_clk);
            #1;
        end
    endtask

    // Full frame, LSB first; optional gaps of (i%4) cycles between bits
    task automatic send_word(input logic [WIDTH-1:0] w, input bit with_gaps);
        for (int i = 0; i < WIDTH; i++) begin
            send_bit(w[i], i == 0);
            if (with_gaps && i < WIDTH - 1) gap(i % 4);
        end
    endtask

    initial begin
        r          = 1'b0;
        y_in       = 1'b0;
        bit_en     = 1'b0;
        sof        = 1'b0;
        word_ready = 1'b1;
        clr_ovr    = 1'b0;

        // Reset state
        repeat (3) @(posedge t_clk);
        #1;
        chk("rst_word_out", word_out, 8'h00);
        chk("rst_valid", word_valid, 1'b0);
        chk("rst_sign", sign, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        @(negedge t_clk);
        r = 1'b1;
        gap(2);
        chk("rel_valid", word_valid, 1'b0);

        // Basic frame 0xA5 with continuous bit_en
        for (int i = 0; i < 7; i++) send_bit(i == 0 || i == 2 || i == 5, i == 0);
        chk("a5_not_yet_valid", word_valid, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("a5_valid", word_valid, 1'b1);
        chk("a5_word", word_out, 8'hA5);
        chk("a5_sign", sign, 1'b1);
        gap(1);
        chk("a5_valid_one_cycle", word_valid, 1'b0);
        chk("a5_word_hold", word_out, 8'hA5);

        // Overrun: hold ready low, second word must be dropped
        word_ready = 1'b0;
        send_word(8'h01, 1'b0);
        chk("ovr_first_valid", word_valid, 1'b1);
        chk("ovr_first_word", word_out, 8'h01);
        gap(2);
        chk("ovr_held_valid", word_valid, 1'b1);
        send_word(8'h7F, 1'b0);
        chk("ovr_word_kept", word_out, 8'h01);
        chk("ovr_sign_kept", sign, 1'b0);
        chk("ovr_set", overrun, 1'b1);
        gap(3);
        chk("ovr_sticky", overrun, 1'b1);
        @(negedge t_clk);
        clr_ovr = 1'b1;
        @(posedge t_clk);
        #1;
        chk("ovr_cleared", overrun, 1'b0);
        @(negedge t_clk);
        clr_ovr = 1'b0;

        // Clear and a new drop in the same cycle keep overrun set
        send_word(8'h55, 1'b0);
        chk("ovr_again", overrun, 1'b1);
        @(negedge t_clk);
        clr_ovr = 1'b1;
        @(posedge t_clk);
        #1;
        chk("ovr_clr_only", overrun, 1'b0);
        for (int i = 0; i < 7; i++) send_bit(1'b0, i == 0);
        send_bit(1'b0, 1'b0);   // completes with clr_ovr still high
        chk("ovr_clr_and_drop", overrun, 1'b1);
        chk("ovr_clr_word_kept", word_out, 8'h01);
        @(negedge t_clk);
        clr_ovr    = 1'b0;
        word_ready = 1'b1;
        bit_en     = 1'b0;
        @(posedge t_clk);
        #1;
        chk("ovr_consumed", word_valid, 1'b0);
        @(negedge t_clk);
        clr_ovr = 1'b1;
        gap(1);
        clr_ovr = 1'b0;

        // Aborted frame followed by 0xFF
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        chk("abort_no_err_yet", frame_err, 1'b0);
        send_bit(1'b1, 1'b1);
        chk("abort_err_pulse", frame_err, 1'b1);
        send_bit(1'b1, 1'b0);
        chk("abort_err_one_cycle", frame_err, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        chk("abort_not_early", word_valid, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("abort_valid", word_valid, 1'b1);
        chk("abort_word", word_out, 8'hFF);
        chk("abort_sign", sign, 1'b1);
        gap(2);

        // Reset mid-frame, stray bits, then 0x3C
        cap_w.delete();
        cap_s.delete();
        mon_en = 1'b1;
        for (int i = 0; i < 5; i++) send_bit(1'b1, i == 0);
        @(negedge t_clk);
        bit_en = 1'b0;
        r      = 1'b0;
        #1;
        chk("midrst_word", word_out, 8'h00);
        chk("midrst_sign", sign, 1'b0);
        @(negedge t_clk);
        r = 1'b1;
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        gap(1);
        chk("midrst_stray_ignored", word_valid, 1'b0);
        send_word(8'h3C, 1'b0);
        gap(3);
        chk("midrst_count", cap_w.size(), 1);
        if (cap_w.size() >= 1) begin
            chk("midrst_word_3c", cap_w[0], 8'h3C);
            chk("midrst_sign_3c", cap_s[0], 1'b0);
        end

        // Back-to-back frames with bit gaps
        cap_w.delete();
        cap_s.delete();
        send_word(8'h80, 1'b1);
        send_word(8'h00, 1'b1);
        gap(3);
        mon_en = 1'b0;
        chk("b2b_count", cap_w.size(), 2);
        if (cap_w.size() >= 2) begin
            chk("b2b_word0", cap_w[0], 8'h80);
            chk("b2b_sign0", cap_s[0], 1'b1);
            chk("b2b_word1", cap_w[1], 8'h00);
            chk("b2b_sign1", cap_s[1], 1'b0);
        end
        chk("b2b_no_overrun", overrun, 1'b0);
        chk("b2b_no_frame_err", frame_err, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_deser.md
SERIAL_DESER -- requirements
Module: serial_deser

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning bits per serial word; legal range 2..32.
REQ-002 SHALL have port t_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port r, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port y_in, input, 1 bit: serial data from the upstream bit-serial two's-complement stage, LSB first.
REQ-005 SHALL have port bit_en, input, 1 bit: y_in is valid this cycle.
REQ-006 SHALL have port sof, input, 1 bit: start of frame; qualified by bit_en; marks the current bit as bit 0 (LSB).
REQ-007 SHALL have port word_ready, input, 1 bit: downstream accepts word_out this cycle.
REQ-008 SHALL have port clr_ovr, input, 1 bit: synchronous clear of overrun.
REQ-009 SHALL have port word_out, output, WIDTH bits: assembled parallel word, registered.
REQ-010 SHALL have port word_valid, output, 1 bit: word_out holds an unconsumed word.
REQ-011 SHALL have port sign, output, 1 bit: word_out[WIDTH-1], registered with word_out.
REQ-012 SHALL have port overrun, output, 1 bit: sticky flag; a completed word was dropped.
REQ-013 SHALL have port frame_err, output, 1 bit: one-cycle pulse; a partial frame was aborted.

Function
REQ-014 SHALL implement the states IDLE and SHIFT, plus an internal bit counter of ceil(log2(WIDTH)) bits and a WIDTH-bit shift register.
REQ-015 In IDLE, bit_en=1 and sof=1 SHALL capture y_in as bit 0, set count=1, and go to SHIFT.
REQ-016 In IDLE, bit_en=1 and sof=0 SHALL be ignored, with no state or flag change.
REQ-017 In SHIFT, bit_en=1 and sof=0 SHALL place y_in at bit position count and increment count.
REQ-018 In SHIFT, bit_en=0 SHALL hold all state; gaps of any length are allowed.
REQ-019 In SHIFT, when bit_en=1, sof=0 and count=WIDTH-1, the word SHALL complete: the assembled word including the current bit is offered to the output register, and the FSM returns to IDLE.
REQ-020 In SHIFT, bit_en=1 and sof=1 SHALL abort the partial frame, pulse frame_err for one cycle (next cycle), and restart at bit 0 with count=1, staying in SHIFT.
REQ-021 For WIDTH=2 and up, a completing bit followed by sof on the very next bit_en SHALL be accepted with no idle cycle, so back-to-back frames are supported.
REQ-022 Output register load: on completion, if word_valid=0 or word_ready=1, word_out and sign SHALL load the new word and word_valid SHALL be 1 on the next cycle.
REQ-023 On completion with word_valid=1 and word_ready=0, the new word SHALL be dropped, word_out SHALL be unchanged, and overrun SHALL be set next cycle.
REQ-024 With word_valid=1, word_ready=1 and no completion, word_valid SHALL clear next cycle; word_out SHALL hold its last value.
REQ-025 Total latency from the last bit's bit_en edge to word_valid=1 SHALL be exactly 1 clock.
REQ-026 overrun SHALL remain set until clr_ovr=1; if clr_ovr and a new overrun occur in the same cycle, overrun SHALL remain 1.
REQ-027 The data path SHALL perform no arithmetic; bits SHALL be stored verbatim, so a two's-complement value is preserved and sign reflects its MSB.

Reset
REQ-028 r=0 SHALL asynchronously force: FSM to IDLE, count=0, shift register=0, word_out=0, sign=0, word_valid=0, overrun=0, frame_err=0.
REQ-029 Reset asserted mid-frame SHALL discard the partial word; after r returns to 1, bits without sof SHALL be ignored.
REQ-030 Release of r SHALL be assumed synchronous to t_clk upstream; the block SHALL NOT act on the first edge with r=1 unless bit_en=1.

Verification (WIDTH=8)
REQ-031 Apply serial bits 1,0,1,0,0,1,0,1 with sof on the first bit and bit_en continuous, word_ready=1 -> word_out=8'hA5, sign=1, word_valid=1 for 1 cycle, exactly 1 clock after the last bit.
REQ-032 Send 8'h01, hold word_ready=0, then send 8'h7F -> word_out stays 8'h01, overrun=1 until clr_ovr pulse, then overrun=0.
REQ-033 Send 3 bits of a frame, then sof with a new frame 8'hFF -> frame_err pulses 1 cycle, word_out=8'hFF, sign=1.
REQ-034 Assert r=0 after 5 bits, release, send 3 bits without sof, then a full frame 8'h3C -> only 8'h3C appears, with word_valid asserted once.
REQ-035 Send back-to-back frames 8'h80, 8'h00 with bit_en gaps of 0..3 cycles and word_ready=1 -> two words in order, sign=1 then 0, and no overrun.
